// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit load sequencer: widths, opcode values,
// instruction field positions and the sequencer state encoding.
package cpu4_pkg;

  // Data / register width and PC / data-memory address width.
  localparam int CPU_DW = 4;
  localparam int CPU_AW = 4;

  // Instruction word layout: opcode[7:5], rd[4], operand[3:0].
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int RD_BIT   = 4;
  localparam int OPND_MSB = 3;
  localparam int OPND_LSB = 0;

  // Opcode values; 101 and 110 are unassigned and behave as NOP.
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LDI   = 3'b001;
  localparam logic [2:0] OP_LD    = 3'b010;
  localparam logic [2:0] OP_LDIND = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Sequencer states. S_RD2 is only reachable when indirect loads are built.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RD1    = 3'd2,
    S_RD2    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/rf_load_decode.sv
// Combinational opcode decode for rf_load_sequencer: picks the state that
// follows DECODE and RD1, flags jumps, and selects the write-data source.
// Build option: LD_INDIRECT_EN enables the two-read indirect load (LDIND);
// without it opcode 011 decodes as NOP.
module rf_load_decode
  import cpu4_pkg::*;
(
  input  logic [2:0] opcode_i,
  output state_t     decode_next_o,  // state entered after DECODE
  output state_t     rd1_next_o,     // state entered after RD1
  output logic       is_jmp_o,       // DECODE loads pc from the operand
  output logic       din_imm_o       // write data comes from the operand
);

  // Opcode to control lookup; anything unlisted returns to FETCH as a NOP.
  always_comb begin
    decode_next_o = S_FETCH;
    rd1_next_o    = S_WB;
    is_jmp_o      = 1'b0;
    din_imm_o     = 1'b0;
    case (opcode_i)
      OP_LDI: begin
        decode_next_o = S_WB;
        din_imm_o     = 1'b1;
      end
      OP_LD: begin
        decode_next_o = S_RD1;
      end
`ifdef LD_INDIRECT_EN
      OP_LDIND: begin
        decode_next_o = S_RD1;
        rd1_next_o    = S_RD2;
      end
`endif
      OP_JMP: begin
        is_jmp_o = 1'b1;
      end
      OP_HALT: begin
        decode_next_o = S_HALT;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/rf_load_sequencer.sv
// Multi-cycle load sequencer feeding the two 4-bit register-file registers.
// Fetches from an async instruction ROM, reads data memory (1-cycle latency),
// and issues a one-hot write select with its data for exactly one cycle.
// Build option: LD_INDIRECT_EN adds LDIND (Rd <= M[M[operand]]) via state RD2.
// Handshake: there is no backpressure. dmem_re is a single-cycle read strobe
// and dmem_rdata must be valid on the cycle following it; rf_sel is a
// single-cycle write strobe that the registers act on at the next clk edge.
module rf_load_sequencer
  import cpu4_pkg::*;
#(
  parameter int DW = CPU_DW,
  parameter int AW = CPU_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    instr,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_re,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] rf_din,
  output logic [1:0]    rf_sel,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;

  logic [2:0]    ir_opc;
  logic          ir_rd;
  logic [3:0]    ir_opnd;

  state_t        decode_next;
  state_t        rd1_next;
  logic          is_jmp;
  logic          din_imm;

  logic          re_c;
  logic [AW-1:0] addr_c;
  logic [1:0]    sel_c;
  logic [DW-1:0] din_c;
  logic          halted_c;

  assign ir_opc  = ir_q[OPC_MSB:OPC_LSB];
  assign ir_rd   = ir_q[RD_BIT];
  assign ir_opnd = ir_q[OPND_MSB:OPND_LSB];

  rf_load_decode u_decode (
    .opcode_i      (ir_opc),
    .decode_next_o (decode_next),
    .rd1_next_o    (rd1_next),
    .is_jmp_o      (is_jmp),
    .din_imm_o     (din_imm)
  );

  // State, PC and IR registers; reset drops any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic and raw (ungated) outputs decoded from state and IR.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    re_c     = 1'b0;
    addr_c   = '0;
    sel_c    = 2'b00;
    din_c    = '0;
    halted_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        pc_d    = pc_q + AW'(1);  // wraps 0xF -> 0x0
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = decode_next;
        if (is_jmp) begin
          pc_d = AW'(ir_opnd);
        end
      end
      S_RD1: begin
        re_c    = 1'b1;
        addr_c  = AW'(ir_opnd);
        state_d = rd1_next;
      end
`ifdef LD_INDIRECT_EN
      S_RD2: begin
        // The pointer fetched in RD1 is on dmem_rdata this cycle.
        re_c    = 1'b1;
        addr_c  = AW'(dmem_rdata);
        state_d = S_WB;
      end
`endif
      S_WB: begin
        sel_c   = ir_rd ? 2'b10 : 2'b01;
        din_c   = din_imm ? DW'(ir_opnd) : dmem_rdata;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are masked during reset so no register or memory acts that cycle.
  assign pc        = pc_q;
  assign dmem_addr = addr_c;
  assign dmem_re   = re_c & ~reset;
  assign rf_sel    = sel_c & {2{~reset}};
  assign rf_din    = (rf_sel != 2'b00) ? din_c : '0;
  assign halted    = halted_c;

endmodule

// File: tb/tb_rf_load_sequencer.sv
// Testbench for rf_load_sequencer: directed program scenarios plus random
// programs, checked cycle by cycle against an instruction-level model.
module tb_rf_load_sequencer;

`ifdef LD_INDIRECT_EN
  localparam bit HAS_IND = 1'b1;
`else
  localparam bit HAS_IND = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] instr;
  logic [3:0] pc, dmem_addr, dmem_rdata, rf_din;
  logic       dmem_re, halted;
  logic [1:0] rf_sel;

  logic [7:0] rom  [16];
  logic [3:0] dmem [16];

  assign instr = rom[pc];
  // Synchronous-read data memory: data appears the cycle after the strobe.
  always @(posedge clk) if (dmem_re) dmem_rdata <= dmem[dmem_addr];

  rf_load_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .pc         (pc),
    .dmem_addr  (dmem_addr),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .rf_din     (rf_din),
    .rf_sel     (rf_sel),
    .halted     (halted)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [5:0] exp_q[$];        // expected {rf_sel, rf_din} per register write
  logic [3:0] m_regs [2];      // model register file
  logic [3:0] dut_regs [2];    // registers as loaded by the DUT's strobes
  logic [3:0] m_pc;
  logic       m_halted;
  logic [5:0] mon_got, mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (rf_sel !== 2'b00) begin
      mon_got = {rf_sel, rf_din};
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {26'd0, mon_got}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("write", {26'd0, mon_got}, {26'd0, mon_exp});
      end
      if (rf_sel[0]) dut_regs[0] = rf_din;
      if (rf_sel[1]) dut_regs[1] = rf_din;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_sel", rf_sel, 0);
    chk("rst_din", rf_din, 0);
    chk("rst_re", dmem_re, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_q_empty", exp_q.size(), 0);
    reset    = 1'b0;
    m_pc     = 4'd0;
    m_halted = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Executes one instruction of the model and checks every cycle of it.
  // abort_at >= 0 asserts reset on that cycle of the instruction.
  task automatic run_instr(input int abort_at);
    logic [7:0] ir;
    logic [2:0] opc;
    logic       rd, is_load, e_re;
    logic [3:0] opnd, ptr, wdata, pc_inc, e_addr, e_din;
    logic [1:0] e_sel;
    int         n;
    ir     = rom[m_pc];
    opc    = ir[7:5];
    rd     = ir[4];
    opnd   = ir[3:0];
    ptr    = dmem[opnd];
    pc_inc = m_pc + 4'd1;
    if (opc == 3'b011 && !HAS_IND) opc = 3'b000;
    case (opc)
      3'b001:  n = 3;
      3'b010:  n = 4;
      3'b011:  n = 5;
      default: n = 2;
    endcase
    is_load = (opc == 3'b001) || (opc == 3'b010) || (opc == 3'b011);
    wdata   = (opc == 3'b001) ? opnd : (opc == 3'b010) ? dmem[opnd] : dmem[ptr];
    if (is_load && abort_at < 0) exp_q.push_back({(rd ? 2'b10 : 2'b01), wdata});
    for (int k = 0; k < n; k++) begin
      e_re = 1'b0; e_addr = 4'd0; e_sel = 2'b00; e_din = 4'd0;
      if (k == 2 && (opc == 3'b010 || opc == 3'b011)) begin e_re = 1'b1; e_addr = opnd; end
      if (k == 3 && opc == 3'b011) begin e_re = 1'b1; e_addr = ptr; end
      if (k == n - 1 && is_load) begin e_sel = rd ? 2'b10 : 2'b01; e_din = wdata; end
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_sel", rf_sel, 0);
        chk("abort_re", dmem_re, 0);
        @(negedge clk);
        chk("abort_pc", pc, 0);
        chk("abort_sel_after", rf_sel, 0);
        reset    = 1'b0;
        m_pc     = 4'd0;
        m_halted = 1'b0;
        return;
      end
      chk("pc", pc, (k == 0) ? m_pc : pc_inc);
      chk("re", dmem_re, e_re);
      chk("addr", dmem_addr, e_addr);
      chk("sel", rf_sel, e_sel);
      chk("din", rf_din, e_din);
      chk("halted", halted, 0);
      @(negedge clk);
    end
    m_pc = (opc == 3'b100) ? opnd : pc_inc;
    if (opc == 3'b111) m_halted = 1'b1;
    if (is_load) m_regs[rd] = wdata;
  endtask

  // Watchdog: the run is a few thousand cycles at most.
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  logic [3:0] old_r1;

  initial begin
    m_regs[0] = 4'd0; m_regs[1] = 4'd0;
    dut_regs[0] = 4'd0; dut_regs[1] = 4'd0;
    for (int i = 0; i < 16; i++) dmem[i] = 4'(i);
    clear_rom();

    // LDI R1,0xA at pc0
    rom[0] = 8'h3A;
    do_reset();
    run_instr(-1);
    chk("ldi_r1", dut_regs[1], 4'hA);
    chk("ldi_pc_after", pc, 4'h1);

    // LD R0,[3] with M[3]=7
    clear_rom();
    rom[0] = 8'h43;
    dmem[3] = 4'h7;
    do_reset();
    run_instr(-1);
    chk("ld_r0", dut_regs[0], 4'h7);

    // LDIND R1,[[2]] with M[2]=9, M[9]=5
    clear_rom();
    rom[0] = 8'h72;
    dmem[2] = 4'h9; dmem[9] = 4'h5;
    old_r1 = dut_regs[1];
    do_reset();
    run_instr(-1);
`ifdef LD_INDIRECT_EN
    chk("ldind_r1", dut_regs[1], 4'h5);
`else
    chk("ldind_nop_r1", dut_regs[1], old_r1);
    chk("ldind_nop_pc", pc, 4'h1);
`endif

    // PC wrap: JMP 0xF then NOP at 0xF
    clear_rom();
    rom[0] = 8'h8F;
    do_reset();
    run_instr(-1);
    chk("jmp_f_pc", pc, 4'hF);
    run_instr(-1);
    chk("wrap_pc", pc, 4'h0);

    // JMP 0xC
    clear_rom();
    rom[0] = 8'h8C;
    do_reset();
    run_instr(-1);
    chk("jmp_c_pc", pc, 4'hC);

    // HALT holds for 20 cycles, then reset releases it
    clear_rom();
    rom[0] = 8'hE0;
    do_reset();
    run_instr(-1);
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, 4'h1);
      chk("halt_sel", rf_sel, 0);
      chk("halt_re", dmem_re, 0);
      @(negedge clk);
    end
    do_reset();
    chk("unhalt_flag", halted, 0);

    // Reset in the last read state of a load aborts the write
    clear_rom();
    old_r1 = dut_regs[1];
`ifdef LD_INDIRECT_EN
    rom[0] = 8'h72;
    do_reset();
    run_instr(3);
`else
    rom[0] = 8'h53;
    do_reset();
    run_instr(2);
`endif
    chk("abort_fetch_pc", pc, 4'h0);
    chk("abort_r1_kept", dut_regs[1], old_r1);

    // Random programs (HALT replaced by NOP so the run keeps going)
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i]  = 8'($urandom_range(0, 255));
        if (rom[i][7:5] == 3'b111) rom[i][7:5] = 3'b000;
        dmem[i] = 4'($urandom_range(0, 15));
      end
      do_reset();
      for (int j = 0; j < 30; j++) run_instr(-1);
    end

    // ---------------- final report ----------------
    @(negedge clk);
    chk("final_q_drained", exp_q.size(), 0);
    chk("final_r0", dut_regs[0], m_regs[0]);
    chk("final_r1", dut_regs[1], m_regs[1]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_load_sequencer.md
Name: rf_load_sequencer

Overview:
- Multi-cycle control sequencer directly upstream of the 4-bit register-file registers.
- Fetches 8-bit instructions and decodes load-class opcodes, including load-indirect.
- Drives the data-memory read port.
- Produces, per register, the one-hot write-select and 4-bit write data consumed by each register's Sel/Din inputs.
- Owns the PC and IR.

Parameters:
DW, 4, data/register width.
AW, 4, PC and data-memory address width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
instr  in  8  instruction word from the async instruction ROM at address pc.
pc  out  AW  program counter.
dmem_addr  out  AW  data-memory read address.
dmem_re  out  1  data-memory read strobe; dmem_rdata is valid the cycle after.
dmem_rdata  in  DW  data-memory read data.
rf_din  out  DW  write data to both registers (R0/R1 Din).
rf_sel  out  2  one-hot write select: bit0 to R0, bit1 to R1.
halted  out  1  high while in HALT.

Behaviour:
- Instruction format: opcode=instr[7:5], rd=instr[4], operand=instr[3:0].
- Opcodes:
  - 000 NOP
  - 001 LDI: Rd<=operand
  - 010 LD: Rd<=M[operand]
  - 011 LDIND: Rd<=M[M[operand]]
  - 100 JMP: pc<=operand
  - 111 HALT
  - 101/110 execute as NOP.
- States: FETCH, DECODE, RD1, RD2, WB, HALT. State register and IR are clocked on clk.
- FETCH: IR<=instr; pc<=pc+1, mod 16 (0xF wraps to 0x0). Next state DECODE.
- DECODE transitions:
  - LDI to WB.
  - LD, LDIND to RD1.
  - JMP: pc<=operand, then FETCH.
  - HALT to HALT.
  - NOP/undefined to FETCH.
- RD1: dmem_re=1, dmem_addr=operand. LD goes to WB; LDIND goes to RD2.
- RD2 (LDIND only): dmem_re=1, dmem_addr=dmem_rdata (pointer returned from RD1). Next state WB.
- WB: rf_sel=1<<rd for exactly one cycle. rf_din=operand for LDI, else dmem_rdata. Next state FETCH.
- HALT: sticky; halted=1; only reset exits.
- Cycles per instruction: NOP 2, JMP 2, LDI 3, LD 4, LDIND 5.
- Outputs are combinational from state/IR.
- rf_sel=0 outside WB; rf_din=0 when rf_sel=0; dmem_re=0 and dmem_addr=0 outside RD1/RD2.
- rf_sel and dmem_re are gated low while reset=1, so registers never load in a reset cycle.
- Reset: on the clk edge with reset=1, state<=FETCH, pc<=0, IR<=0. All outputs read 0 afterwards.
- Reset mid-instruction aborts it with no register write.

Optional Feature:
LD_INDIRECT_EN:
- Defined: LDIND (011) is supported as above, including state RD2.
- Undefined: RD2 is not built; opcode 011 decodes as NOP (2 cycles, no memory read, no write).

Decomposition:
- Package cpu4_pkg:
  - opcode localparams (OP_NOP, OP_LDI, OP_LD, OP_LDIND, OP_JMP, OP_HALT)
  - state enum typedef
  - DW/AW width constants
  - instruction field bit positions
- One natural sub-module, rf_load_decode: combinational opcode-to-next-state and rf_din source select. The FSM, PC and IR stay in the top module.

Test Plan:
- Reset then LDI R1,0xA at pc0 -> rf_sel=2'b10, rf_din=0xA in cycle 3; pc=1 afterwards.
- LD R0,[0x3] with M[3]=0x7 -> dmem_re in cycle 3 at addr 3; cycle 4 rf_sel=2'b01, rf_din=0x7.
- LDIND R1,[[0x2]] with M[2]=0x9, M[9]=0x5:
  - cycle 3 addr 2, cycle 4 addr 9, cycle 5 rf_sel=2'b10, rf_din=0x5.
  - With LD_INDIRECT_EN undefined -> no dmem_re, no rf_sel, 2 cycles.
- pc=0xF executing NOP -> pc wraps to 0x0; JMP 0xC -> next fetch at pc=0xC.
- HALT -> halted=1 held for 20 cycles, pc frozen, rf_sel=0; reset -> halted=0, pc=0.
- reset asserted during RD2 of LDIND -> rf_sel never asserts; FETCH at pc=0 next cycle.
